// File: rtl/text_console_writer_pkg.sv
// text_console_writer_pkg: screen geometry, control codes and FSM encoding
// shared by the console writer and its cursor.
package text_console_writer_pkg;
   localparam int COLS     = 80;
   localparam int ROWS     = 60;
   localparam int TEXT_LEN = COLS * ROWS;
   localparam logic [7:0] CC_BS = 8'h08;
   localparam logic [7:0] CC_LF = 8'h0A;
   localparam logic [7:0] CC_FF = 8'h0C;
   localparam logic [7:0] CC_CR = 8'h0D;
   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, CLEAR = 2'd2} state_t;
endpackage

// File: rtl/text_console_writer_console_cursor.sv
// console_cursor: col/row registers with single-priority updates
// (home > newline > carriage_return > backspace > advance) and linear cell offset.
module console_cursor
   import text_console_writer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        advance,
   input  logic        newline,
   input  logic        carriage_return,
   input  logic        backspace,
   input  logic        home,
   output logic [6:0]  col,
   output logic [5:0]  row,
   output logic [12:0] offset
);
   localparam logic [6:0] COL_MAX = 7'(COLS - 1);
   localparam logic [5:0] ROW_MAX = 6'(ROWS - 1);
   logic [6:0] col_q, col_d;
   logic [5:0] row_q, row_d;
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (home) begin
         col_d = '0;
         row_d = '0;
      end else if (newline) begin
         col_d = '0;
         row_d = (row_q == ROW_MAX) ? '0 : row_q + 6'd1;
      end else if (carriage_return) begin
         col_d = '0;
      end else if (backspace) begin
         if (col_q != '0) begin
            col_d = col_q - 7'd1;
         end else if (row_q != '0) begin
            col_d = COL_MAX;
            row_d = row_q - 6'd1;
         end
      end else if (advance) begin
         col_d = (col_q == COL_MAX) ? '0 : col_q + 7'd1;
         if (col_q == COL_MAX) row_d = (row_q == ROW_MAX) ? '0 : row_q + 6'd1;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end
   assign col    = col_q;
   assign row    = row_q;
   assign offset = 13'(row_q) * 13'(COLS) + 13'(col_q);
endmodule

// File: rtl/text_console_writer.sv
// text_console_writer: turns a {colour, ASCII} character stream into single-cycle
// text-page writes, handling CR/LF/BS locally and FF as a full-screen clear.
module text_console_writer
   import text_console_writer_pkg::*;
#(
   parameter logic [31:0] BASE     = 32'd32768,
   parameter logic [7:0]  CLR_CHAR = 8'h20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        char_valid,
   output logic        char_ready,
   input  logic [7:0]  char_in,
   input  logic [7:0]  colour_in,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [31:0] address,
   output logic [15:0] data_out,
   output logic        writeEn,
   output logic        busy,
   output logic [6:0]  cursor_col,
   output logic [5:0]  cursor_row
);
   localparam logic [12:0] LAST_IDX = 13'(TEXT_LEN - 1);
   state_t      state_q, state_d;
   logic [12:0] clear_idx_q, clear_idx_d;
   logic [31:0] address_q, address_d;
   logic [15:0] data_q, data_d;
   logic [12:0] offset;
   logic        transfer, is_ctrl, printable, form_feed, clear_last;
   assign transfer   = char_valid & char_ready;
   assign is_ctrl    = (char_in == CC_BS) | (char_in == CC_LF) | (char_in == CC_FF) | (char_in == CC_CR);
   assign printable  = transfer & ~is_ctrl;
   assign form_feed  = transfer & (char_in == CC_FF);
   assign clear_last = (state_q == CLEAR) & writeEn & (clear_idx_q == LAST_IDX);
   console_cursor u_cursor (
      .clk             (clk),
      .reset           (reset),
      .advance         ((state_q == WRITE) & writeEn),
      .newline         (transfer & (char_in == CC_LF)),
      .carriage_return (transfer & (char_in == CC_CR)),
      .backspace       (transfer & (char_in == CC_BS)),
      .home            (clear_last),
      .col             (cursor_col),
      .row             (cursor_row),
      .offset          (offset)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         clear_idx_q <= '0;
         address_q   <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         clear_idx_q <= clear_idx_d;
         address_q   <= address_d;
         data_q      <= data_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = form_feed ? CLEAR : printable ? WRITE : IDLE;
         WRITE:   state_d = writeEn ? IDLE : WRITE;
         CLEAR:   state_d = clear_last ? IDLE : CLEAR;
         default: state_d = IDLE;
      endcase
   end
   // The clear colour lives in data_q's upper byte for the whole clear.
   always_comb begin
      clear_idx_d = clear_idx_q;
      address_d   = address_q;
      data_d      = data_q;
      if (form_feed) begin
         clear_idx_d = '0;
         address_d   = BASE;
         data_d      = {colour_in, CLR_CHAR};
      end else if (printable) begin
         address_d = BASE + {19'd0, offset};
         data_d    = {colour_in, char_in};
      end else if ((state_q == CLEAR) & writeEn) begin
         clear_idx_d = clear_last ? '0 : clear_idx_q + 13'd1;
         address_d   = BASE + {19'd0, clear_idx_d};
      end
   end
   always_comb begin
      char_ready = (state_q == IDLE);
      bus_req    = (state_q == WRITE) | (state_q == CLEAR);
      busy       = bus_req;
      writeEn    = bus_req & bus_gnt;
      address    = address_q;
      data_out   = data_q;
   end
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: directed scenarios with hand-computed expectations
// for writes, cursor control codes, stalls, full clear and reset mid-clear.
module tb_text_console_writer;
   logic        clk = 1'b0, reset = 1'b1, char_valid = 1'b0, bus_gnt = 1'b0;
   logic [7:0]  char_in = 8'h00, colour_in = 8'h00;
   logic        char_ready, bus_req, writeEn, busy;
   logic [31:0] address;
   logic [15:0] data_out;
   logic [6:0]  cursor_col;
   logic [5:0]  cursor_row;
   int errors = 0, checks = 0;
   int pulses = 0;
   logic [31:0] last_addr = '0;
   bit count_en = 1'b0;

   always #5 clk = ~clk;

   text_console_writer dut (
      .clk(clk), .reset(reset), .char_valid(char_valid), .char_ready(char_ready),
      .char_in(char_in), .colour_in(colour_in), .bus_req(bus_req), .bus_gnt(bus_gnt),
      .address(address), .data_out(data_out), .writeEn(writeEn), .busy(busy),
      .cursor_col(cursor_col), .cursor_row(cursor_row)
   );

   always @(negedge clk) if (count_en && writeEn) begin
      pulses++;
      last_addr = address;
   end

   task automatic send(input logic [7:0] c, input logic [7:0] col);
      char_in = c; colour_in = col; char_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      char_valid = 1'b0; char_in = 8'hFF; colour_in = 8'hEE;
   endtask

   task automatic put(input logic [7:0] c, input logic [7:0] col, output bit ok);
      send(c, col);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (char_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus_req, writeEn, busy, char_ready} !== 4'b0001) begin
         errors++; $display("FAIL reset_ctrl: got req/we/busy/rdy=%b want 0001", {bus_req, writeEn, busy, char_ready});
      end
      checks++;
      if (address !== 32'd0 || data_out !== 16'd0) begin
         errors++; $display("FAIL reset_bus: got addr=%0d data=%h want 0/0000", address, data_out);
      end
      checks++;
      if (cursor_col !== 7'd0 || cursor_row !== 6'd0) begin
         errors++; $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cursor_col, cursor_row);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_a;
      bus_gnt = 1'b1;
      send(8'h41, 8'h1F);
      checks++;
      if ({writeEn, char_ready} !== 2'b10 || address !== 32'd32768 || data_out !== 16'h1F41) begin
         errors++; $display("FAIL write_a: got we=%b rdy=%b addr=%0d data=%h want 1 0 32768 1f41", writeEn, char_ready, address, data_out);
      end
      @(negedge clk);
      checks++;
      if ({writeEn, bus_req, char_ready} !== 3'b001 || cursor_col !== 7'd1 || cursor_row !== 6'd0) begin
         errors++; $display("FAIL write_a_after: got we=%b req=%b rdy=%b cur=(%0d,%0d) want 0 0 1 (1,0)", writeEn, bus_req, char_ready, cursor_col, cursor_row);
      end
   endtask

   task automatic test_wrap;
      bit ok, all_ok;
      send(8'h0D, 8'h00);
      for (int i = 0; i < 59; i++) send(8'h0A, 8'h00);
      checks++;
      if (cursor_col !== 7'd0 || cursor_row !== 6'd59) begin
         errors++; $display("FAIL wrap_lf59: got (%0d,%0d) want (0,59)", cursor_col, cursor_row);
      end
      all_ok = 1'b1;
      for (int i = 0; i < 79; i++) begin
         put(8'h78, 8'h07, ok);
         all_ok &= ok;
      end
      checks++;
      if (!all_ok || cursor_col !== 7'd79 || cursor_row !== 6'd59) begin
         errors++; $display("FAIL wrap_fill: got ok=%b (%0d,%0d) want 1 (79,59)", all_ok, cursor_col, cursor_row);
      end
      send(8'h5A, 8'h2A);
      checks++;
      if (writeEn !== 1'b1 || address !== 32'd37567 || data_out !== 16'h2A5A) begin
         errors++; $display("FAIL wrap_write: got we=%b addr=%0d data=%h want 1 37567 2a5a", writeEn, address, data_out);
      end
      @(negedge clk);
      checks++;
      if (char_ready !== 1'b1 || cursor_col !== 7'd0 || cursor_row !== 6'd0) begin
         errors++; $display("FAIL wrap_home: got rdy=%b (%0d,%0d) want 1 (0,0)", char_ready, cursor_col, cursor_row);
      end
   endtask

   task automatic test_control;
      bit ok, all_ok;
      send(8'h0A, 8'h00);
      send(8'h0A, 8'h00);
      all_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         put(8'h79, 8'h07, ok);
         all_ok &= ok;
      end
      checks++;
      if (!all_ok || cursor_col !== 7'd5 || cursor_row !== 6'd2) begin
         errors++; $display("FAIL ctrl_start: got ok=%b (%0d,%0d) want 1 (5,2)", all_ok, cursor_col, cursor_row);
      end
      pulses = 0;
      count_en = 1'b1;
      send(8'h48, 8'h4E);
      @(negedge clk);
      checks++;
      if (cursor_col !== 7'd6 || cursor_row !== 6'd2) begin
         errors++; $display("FAIL ctrl_h: got (%0d,%0d) want (6,2)", cursor_col, cursor_row);
      end
      send(8'h0A, 8'h00);
      checks++;
      if (cursor_col !== 7'd0 || cursor_row !== 6'd3 || char_ready !== 1'b1) begin
         errors++; $display("FAIL ctrl_lf: got rdy=%b (%0d,%0d) want 1 (0,3)", char_ready, cursor_col, cursor_row);
      end
      send(8'h0D, 8'h00);
      checks++;
      if (cursor_col !== 7'd0 || cursor_row !== 6'd3) begin
         errors++; $display("FAIL ctrl_cr: got (%0d,%0d) want (0,3)", cursor_col, cursor_row);
      end
      send(8'h08, 8'h00);
      checks++;
      if (cursor_col !== 7'd79 || cursor_row !== 6'd2) begin
         errors++; $display("FAIL ctrl_bs: got (%0d,%0d) want (79,2)", cursor_col, cursor_row);
      end
      count_en = 1'b0;
      checks++;
      if (pulses !== 1 || last_addr !== 32'd32933) begin
         errors++; $display("FAIL ctrl_pulses: got n=%0d addr=%0d want 1 32933", pulses, last_addr);
      end
   endtask

   task automatic test_stall;
      bit held;
      bus_gnt = 1'b0;
      send(8'h71, 8'h33);
      held = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if ({bus_req, writeEn, char_ready, busy} !== 4'b1001 || address !== 32'd33007 || data_out !== 16'h3371) held = 1'b0;
         char_valid = 1'b1; char_in = 8'(i);
         @(negedge clk);
      end
      char_valid = 1'b0;
      checks++;
      if (!held || bus_req !== 1'b1 || address !== 32'd33007) begin
         errors++; $display("FAIL stall_hold: got held=%b req=%b addr=%0d want 1 1 33007", held, bus_req, address);
      end
      bus_gnt = 1'b1;
      #1;
      checks++;
      if (writeEn !== 1'b1 || address !== 32'd33007 || data_out !== 16'h3371) begin
         errors++; $display("FAIL stall_grant: got we=%b addr=%0d data=%h want 1 33007 3371", writeEn, address, data_out);
      end
      @(negedge clk);
      checks++;
      if ({bus_req, writeEn, char_ready} !== 3'b001 || cursor_col !== 7'd0 || cursor_row !== 6'd3) begin
         errors++; $display("FAIL stall_done: got req/we/rdy=%b (%0d,%0d) want 001 (0,3)", {bus_req, writeEn, char_ready}, cursor_col, cursor_row);
      end
   endtask

   task automatic test_clear;
      int writes = 0, bad = 0, cyc = 0;
      bit done = 1'b0;
      bus_gnt = 1'b0;
      send(8'h0C, 8'h07);
      checks++;
      if (busy !== 1'b1 || char_ready !== 1'b0) begin
         errors++; $display("FAIL clear_busy: got busy=%b rdy=%b want 1 0", busy, char_ready);
      end
      while (cyc < 12000) begin
         bus_gnt = ~bus_gnt;
         #1;
         if (writeEn) begin
            if (address !== 32'(32768 + writes) || data_out !== 16'h0720) bad++;
            writes++;
         end
         if (char_ready) begin done = 1'b1; break; end
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!done || writes !== 4800 || bad !== 0) begin
         errors++; $display("FAIL clear_writes: got done=%b writes=%0d bad=%0d want 1 4800 0", done, writes, bad);
      end
      checks++;
      if (cyc !== 9599 || cursor_col !== 7'd0 || cursor_row !== 6'd0) begin
         errors++; $display("FAIL clear_end: got cyc=%0d (%0d,%0d) want 9599 (0,0)", cyc, cursor_col, cursor_row);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_clear;
      bit ok;
      int n = 0;
      bus_gnt = 1'b1;
      put(8'h72, 8'h07, ok);
      send(8'h0C, 8'h07);
      for (int i = 0; i < 200; i++) begin
         if (writeEn) n++;
         if (n == 100) break;
         @(negedge clk);
      end
      checks++;
      if (!ok || n !== 100 || address !== 32'd32867 || cursor_col !== 7'd1) begin
         errors++; $display("FAIL midclr_pre: got ok=%b n=%0d addr=%0d col=%0d want 1 100 32867 1", ok, n, address, cursor_col);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({bus_req, writeEn, busy, char_ready} !== 4'b0001 || cursor_col !== 7'd0 || cursor_row !== 6'd0 || address !== 32'd0) begin
         errors++; $display("FAIL midclr_reset: got req/we/busy/rdy=%b (%0d,%0d) addr=%0d want 0001 (0,0) 0", {bus_req, writeEn, busy, char_ready}, cursor_col, cursor_row, address);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus_req, writeEn, char_ready} !== 3'b001) begin
         errors++; $display("FAIL midclr_noresume: got req/we/rdy=%b want 001", {bus_req, writeEn, char_ready});
      end
   endtask

   initial begin
      test_reset();
      test_write_a();
      test_wrap();
      test_control();
      test_stall();
      test_clear();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
